// File: rtl/c7b_mem_pkg.sv
// ---------------------------------------------------------------------------
// c7b_mem_pkg
// Shared definitions for the c7bmem_arb memory-port arbiter:
//   - default address/data widths and starvation limit
//   - FSM state encoding (IDLE, REQ, WAIT)
//   - transaction owner encoding (OWN_IFU = 0, OWN_LSU = 1)
// ---------------------------------------------------------------------------
package c7b_mem_pkg;

  localparam int ADDR_W_DEF     = 32;
  localparam int DATA_W_DEF     = 64;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

endpackage

// File: rtl/c7bmem_arb_if.sv
// ---------------------------------------------------------------------------
// c7bmem_arb_if
// Memory bus between the arbiter and the bus interface unit.
//   mem_req/mem_addr/mem_wr/mem_wdata/mem_wstrb : request, driven by master
//   mem_ack   : request accepted this cycle, driven by slave
//   mem_rvld  : response / write completion, driven by slave
//   mem_rdata : response data, driven by slave
// Modports: master (the arbiter), slave (the bus side).
// ---------------------------------------------------------------------------
interface c7bmem_arb_if
  import c7b_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic                  mem_req;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_wr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wstrb;
  logic                  mem_ack;
  logic                  mem_rvld;
  logic [DATA_W-1:0]     mem_rdata;

  modport master (
    output mem_req, mem_addr, mem_wr, mem_wdata, mem_wstrb,
    input  mem_ack, mem_rvld, mem_rdata
  );

  modport slave (
    input  mem_req, mem_addr, mem_wr, mem_wdata, mem_wstrb,
    output mem_ack, mem_rvld, mem_rdata
  );

endinterface

// File: rtl/c7bmem_arb.sv
// ---------------------------------------------------------------------------
// c7bmem_arb
// Shares the core's single memory port between instruction fetch and the
// LSU. One transaction is outstanding at a time; the response is routed to
// the owner. Fetches killed by a front-end flush are drained silently. LSU
// has fixed priority, limited by a starvation counter that forces fetch to
// win after STARVE_MAX consecutive LSU grants with fetch waiting.
//
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   ifu_req/ifu_addr  : fetch read request (held until ack or cancel)
//   ifu_cancel        : front-end flush, kills pending/in-flight fetch
//   ifu_ack           : fetch accepted by memory
//   ifu_data_vld/data : fetch response
//   lsu_req/addr/wr/wdata/wstrb : LSU request (held until ack)
//   lsu_ack           : LSU request accepted
//   lsu_data_vld/rdata: LSU read data or write-complete pulse
//   mem               : memory bus, master side
// ---------------------------------------------------------------------------
module c7bmem_arb
  import c7b_mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                ifu_req,
  input  logic [ADDR_W-1:0]   ifu_addr,
  input  logic                ifu_cancel,
  output logic                ifu_ack,
  output logic                ifu_data_vld,
  output logic [DATA_W-1:0]   ifu_data,

  input  logic                lsu_req,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  output logic                lsu_ack,
  output logic                lsu_data_vld,
  output logic [DATA_W-1:0]   lsu_rdata,

  c7bmem_arb_if.master        mem
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  state_t           state;
  state_t           state_nxt;
  owner_t           owner;
  logic             drop;
  logic [CNT_W-1:0] starve_cnt;

  logic             fetch_elig;
  logic             grant;
  logic             lsu_win;
  logic             ifu_live;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state, arbitration and the combinational handshake outputs.
  // Acks follow mem_ack directly; data valids follow mem_rvld directly.
  // ifu_live folds the flush state so a killed fetch never signals upward.
  // Data outputs are gated by their valid so they read zero when idle.
  always_comb begin
    state_nxt    = state;
    fetch_elig   = ifu_req & ~ifu_cancel;
    grant        = 1'b0;
    lsu_win      = 1'b0;
    ifu_live     = (owner == OWN_IFU) & ~drop & ~ifu_cancel;
    ifu_ack      = 1'b0;
    lsu_ack      = 1'b0;
    ifu_data_vld = 1'b0;
    lsu_data_vld = 1'b0;
    ifu_data     = '0;
    lsu_rdata    = '0;
    case (state)
      IDLE: begin
        if (lsu_req | fetch_elig) begin
          grant     = 1'b1;
          // LSU loses only when fetch is eligible and has been starved.
          lsu_win   = lsu_req & (~fetch_elig | (starve_cnt < CNT_MAX));
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (mem.mem_ack) begin
          state_nxt = WAIT;
          lsu_ack   = (owner == OWN_LSU);
          ifu_ack   = ifu_live;
        end
      end
      WAIT: begin
        if (mem.mem_rvld) begin
          state_nxt = IDLE;
          if (owner == OWN_LSU) begin
            lsu_data_vld = 1'b1;
            lsu_rdata    = mem.mem_rdata;
          end else if (ifu_live) begin
            ifu_data_vld = 1'b1;
            ifu_data     = mem.mem_rdata;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request registers, owner, starvation counter and the drop flag.
  // The bus request is loaded at grant and held until mem_ack. The drop
  // flag remembers a flush that hit our own fetch so its ack and response
  // are swallowed; it clears whenever the FSM returns to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner         <= OWN_IFU;
      drop          <= 1'b0;
      starve_cnt    <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wr    <= 1'b0;
      mem.mem_wdata <= '0;
      mem.mem_wstrb <= '0;
    end else begin
      if (grant) begin
        owner         <= lsu_win ? OWN_LSU : OWN_IFU;
        mem.mem_req   <= 1'b1;
        mem.mem_addr  <= lsu_win ? lsu_addr : ifu_addr;
        mem.mem_wr    <= lsu_win & lsu_wr;
        mem.mem_wdata <= lsu_win ? lsu_wdata : '0;
        mem.mem_wstrb <= lsu_win ? lsu_wstrb : '0;
        if (lsu_win && fetch_elig) begin
          if (starve_cnt != CNT_MAX) starve_cnt <= starve_cnt + CNT_W'(1);
        end else begin
          starve_cnt <= '0;
        end
      end else if (state == REQ && mem.mem_ack) begin
        mem.mem_req <= 1'b0;
      end

      if (state_nxt == IDLE) begin
        drop <= 1'b0;
      end else if ((state == REQ || state == WAIT) && owner == OWN_IFU && ifu_cancel) begin
        drop <= 1'b1;
      end
    end
  end

  // A response is only legal while a transaction waits for it.
  rvld_only_in_wait: assert property (
    @(posedge clk) disable iff (reset) mem.mem_rvld |-> (state == WAIT)
  );

endmodule

// File: tb/tb_c7bmem_arb.sv
// ---------------------------------------------------------------------------
// tb_c7bmem_arb
// Self-checking bench for c7bmem_arb. A bus/requester model steps one cycle
// at a time: it drives requests and bus responses, predicts every output
// from the arbitration rules (who should win, who gets the ack, who sees
// the data), and checks them on the falling edge.
// ---------------------------------------------------------------------------
module tb_c7bmem_arb;
  import c7b_mem_pkg::*;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 64;
  localparam int STARVE_MAX = 4;
  localparam int STRB_W     = DATA_W / 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              ifu_req, ifu_cancel, ifu_ack, ifu_data_vld;
  logic [ADDR_W-1:0] ifu_addr;
  logic [DATA_W-1:0] ifu_data;
  logic              lsu_req, lsu_wr, lsu_ack, lsu_data_vld;
  logic [ADDR_W-1:0] lsu_addr;
  logic [DATA_W-1:0] lsu_wdata, lsu_rdata;
  logic [STRB_W-1:0] lsu_wstrb;

  c7bmem_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

  c7bmem_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk          (clk),
    .reset        (reset),
    .ifu_req      (ifu_req),
    .ifu_addr     (ifu_addr),
    .ifu_cancel   (ifu_cancel),
    .ifu_ack      (ifu_ack),
    .ifu_data_vld (ifu_data_vld),
    .ifu_data     (ifu_data),
    .lsu_req      (lsu_req),
    .lsu_addr     (lsu_addr),
    .lsu_wr       (lsu_wr),
    .lsu_wdata    (lsu_wdata),
    .lsu_wstrb    (lsu_wstrb),
    .lsu_ack      (lsu_ack),
    .lsu_data_vld (lsu_data_vld),
    .lsu_rdata    (lsu_rdata),
    .mem          (mem_bus)
  );

  always #5 clk = ~clk;

  typedef enum int {P_IDLE, P_REQ, P_WAIT} bus_phase_t;

  int checks;
  int errors;

  // Requester state.
  bit                lsu_pend, ifu_pend;
  logic [ADDR_W-1:0] l_addr, f_addr;
  bit                l_wr;
  logic [DATA_W-1:0] l_wdata;
  logic [STRB_W-1:0] l_wstrb;

  // Stimulus settings.
  int  lsu_pct, ifu_pct, cancel_pct;
  int  ack_sel, rvld_sel;
  bit  cancel_now;
  bit  fixed_rdata_en;
  logic [DATA_W-1:0] fixed_rdata;

  // Reference model of the shared port.
  bus_phase_t        phase;
  bit                own_lsu;
  bit                killed;
  int                streak;
  int                ack_dly, rvld_dly;
  logic [ADDR_W-1:0] exp_addr;
  bit                exp_wr;
  logic [DATA_W-1:0] exp_wdata;
  logic [STRB_W-1:0] exp_wstrb;

  // What the DUT actually did: acks seen at mem_ack (1 LSU, 0 IFU, 2 none)
  // and the order of visible responses (1 LSU, 0 IFU).
  int dut_grant_q[$];
  int dut_resp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int sel);
    return (sel >= 0) ? sel : int'($urandom_range(0, 2));
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_mem_req"},   64'(mem_bus.mem_req), 64'(0));
    check({tag, "_mem_addr"},  64'(mem_bus.mem_addr), 64'(0));
    check({tag, "_mem_wr"},    64'(mem_bus.mem_wr), 64'(0));
    check({tag, "_mem_wdata"}, 64'(mem_bus.mem_wdata), 64'(0));
    check({tag, "_mem_wstrb"}, 64'(mem_bus.mem_wstrb), 64'(0));
    check({tag, "_ifu_ack"},   64'(ifu_ack), 64'(0));
    check({tag, "_ifu_vld"},   64'(ifu_data_vld), 64'(0));
    check({tag, "_ifu_data"},  64'(ifu_data), 64'(0));
    check({tag, "_lsu_ack"},   64'(lsu_ack), 64'(0));
    check({tag, "_lsu_vld"},   64'(lsu_data_vld), 64'(0));
    check({tag, "_lsu_rdata"}, 64'(lsu_rdata), 64'(0));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ifu_req = 0; ifu_addr = '0; ifu_cancel = 0;
    lsu_req = 0; lsu_addr = '0; lsu_wr = 0; lsu_wdata = '0; lsu_wstrb = '0;
    mem_bus.mem_ack = 0; mem_bus.mem_rvld = 0; mem_bus.mem_rdata = '0;
    lsu_pend = 0; ifu_pend = 0; cancel_now = 0;
    phase = P_IDLE; own_lsu = 0; killed = 0; streak = 0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One clock of stimulus, prediction and checking.
  task automatic apply_stimulus();
    bit grant, win_lsu, fetch_ok, cancel, exp_ifu_ack, exp_ifu_vld, exp_lsu_vld;
    bus_phase_t ph;
    logic [DATA_W-1:0] drove;
    @(posedge clk);
    #1;
    ph = phase;
    mem_bus.mem_ack = 0; mem_bus.mem_rvld = 0; mem_bus.mem_rdata = '0;
    drove = '0;
    if (ph == P_REQ) begin
      if (ack_dly == 0) mem_bus.mem_ack = 1; else ack_dly--;
    end else if (ph == P_WAIT) begin
      if (rvld_dly == 0) begin
        mem_bus.mem_rvld = 1;
        drove = fixed_rdata_en ? fixed_rdata : {$urandom, $urandom};
        mem_bus.mem_rdata = drove;
      end else rvld_dly--;
    end
    if (!lsu_pend && int'($urandom_range(0, 99)) < lsu_pct) begin
      lsu_pend = 1; l_addr = $urandom; l_wr = 1'($urandom_range(0, 1));
      l_wdata = {$urandom, $urandom}; l_wstrb = STRB_W'($urandom);
    end
    if (!ifu_pend && int'($urandom_range(0, 99)) < ifu_pct) begin
      ifu_pend = 1; f_addr = $urandom & 32'hFFFF_FFF8;
    end
    cancel = cancel_now || (int'($urandom_range(0, 99)) < cancel_pct);
    lsu_req = lsu_pend; lsu_addr = l_addr; lsu_wr = l_wr;
    lsu_wdata = l_wdata; lsu_wstrb = l_wstrb;
    ifu_req = ifu_pend; ifu_addr = f_addr; ifu_cancel = cancel;

    fetch_ok = ifu_pend && !cancel;
    grant = (ph == P_IDLE) && (lsu_pend || fetch_ok);
    win_lsu = lsu_pend && (!fetch_ok || streak < STARVE_MAX);

    exp_ifu_ack = mem_bus.mem_ack && !own_lsu && !killed && !cancel;
    exp_lsu_vld = mem_bus.mem_rvld && own_lsu;
    exp_ifu_vld = mem_bus.mem_rvld && !own_lsu && !killed && !cancel;

    @(negedge clk);
    check_output(ph, exp_ifu_ack, exp_lsu_vld, exp_ifu_vld, drove);

    // Advance the model.
    if (cancel) begin
      ifu_pend = 0;
      if (ph != P_IDLE && !own_lsu) killed = 1;
    end
    if (ph == P_REQ && mem_bus.mem_ack) begin
      phase = P_WAIT;
      rvld_dly = pick(rvld_sel);
      if (own_lsu) lsu_pend = 0;
      else if (exp_ifu_ack) ifu_pend = 0;
    end else if (ph == P_WAIT && mem_bus.mem_rvld) begin
      phase = P_IDLE;
      killed = 0;
    end
    if (grant) begin
      phase = P_REQ;
      own_lsu = win_lsu;
      ack_dly = pick(ack_sel);
      exp_addr = win_lsu ? l_addr : f_addr;
      exp_wr = win_lsu && l_wr;
      exp_wdata = l_wdata;
      exp_wstrb = l_wstrb;
      if (win_lsu && fetch_ok) streak = (streak < STARVE_MAX) ? streak + 1 : streak;
      else streak = 0;
    end
  endtask

  task automatic check_output(input bus_phase_t ph, input bit exp_ifu_ack,
                              input bit exp_lsu_vld, input bit exp_ifu_vld,
                              input logic [DATA_W-1:0] drove);
    check("mem_req", 64'(mem_bus.mem_req), 64'(ph == P_REQ));
    if (ph == P_REQ) begin
      check("mem_addr", 64'(mem_bus.mem_addr), 64'(exp_addr));
      check("mem_wr", 64'(mem_bus.mem_wr), 64'(exp_wr));
      if (exp_wr) begin
        check("mem_wdata", 64'(mem_bus.mem_wdata), 64'(exp_wdata));
        check("mem_wstrb", 64'(mem_bus.mem_wstrb), 64'(exp_wstrb));
      end
    end
    check("lsu_ack", 64'(lsu_ack), 64'(mem_bus.mem_ack && own_lsu));
    check("ifu_ack", 64'(ifu_ack), 64'(exp_ifu_ack));
    check("lsu_data_vld", 64'(lsu_data_vld), 64'(exp_lsu_vld));
    if (exp_lsu_vld && !exp_wr) check("lsu_rdata", 64'(lsu_rdata), 64'(drove));
    check("ifu_data_vld", 64'(ifu_data_vld), 64'(exp_ifu_vld));
    if (exp_ifu_vld) check("ifu_data", 64'(ifu_data), 64'(drove));
    if (mem_bus.mem_ack) dut_grant_q.push_back(lsu_ack ? 1 : (ifu_ack ? 0 : 2));
    if (lsu_data_vld) dut_resp_q.push_back(1);
    if (ifu_data_vld) dut_resp_q.push_back(0);
  endtask

  task automatic run(input int n);
    repeat (n) apply_stimulus();
  endtask

  initial begin
    int pat[10];
    checks = 0; errors = 0;
    lsu_pct = 0; ifu_pct = 0; cancel_pct = 0;
    ack_sel = 0; rvld_sel = 0; fixed_rdata_en = 0; fixed_rdata = '0;
    l_addr = '0; l_wr = 0; l_wdata = '0; l_wstrb = '0; f_addr = '0;
    ack_dly = 0; rvld_dly = 0;
    do_reset();

    // Fetch alone at minimum latency with a known response word.
    fixed_rdata_en = 1; fixed_rdata = 64'h0011_2233_4455_6677;
    ifu_pend = 1; f_addr = 32'h1C00_0000;
    run(4);
    fixed_rdata_en = 0;

    // Simultaneous LSU read and fetch: LSU first, fetch at the next IDLE.
    dut_grant_q.delete(); dut_resp_q.delete();
    lsu_pend = 1; l_addr = 32'h0000_1000; l_wr = 0; l_wdata = '0; l_wstrb = '0;
    ifu_pend = 1; f_addr = 32'h1C00_0008;
    run(8);
    check("t2_grant_count", 64'(dut_grant_q.size()), 64'(2));
    check("t2_resp_count", 64'(dut_resp_q.size()), 64'(2));
    if (dut_grant_q.size() >= 2) begin
      check("t2_first_grant", 64'(dut_grant_q[0]), 64'(1));
      check("t2_second_grant", 64'(dut_grant_q[1]), 64'(0));
    end
    if (dut_resp_q.size() >= 2) begin
      check("t2_first_resp", 64'(dut_resp_q[0]), 64'(1));
      check("t2_second_resp", 64'(dut_resp_q[1]), 64'(0));
    end

    // LSU hammering with fetch always pending: fetch wins every fifth grant.
    do_reset();
    dut_grant_q.delete();
    lsu_pct = 100; ifu_pct = 100;
    run(45);
    lsu_pct = 0; ifu_pct = 0;
    run(20);
    pat = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    check("t3_grant_count", 64'(dut_grant_q.size() >= 10), 64'(1));
    for (int i = 0; i < 10; i++) begin
      if (i < dut_grant_q.size()) check($sformatf("t3_grant%0d", i), 64'(dut_grant_q[i]), 64'(pat[i]));
    end

    // Flush during WAIT, response two cycles later, then a normal LSU read.
    dut_grant_q.delete(); dut_resp_q.delete();
    ifu_pend = 1; f_addr = 32'h1C00_0040;
    rvld_sel = 2;
    run(2);
    cancel_now = 1;
    run(1);
    cancel_now = 0;
    run(3);
    rvld_sel = 0;
    lsu_pend = 1; l_addr = 32'h0000_3000; l_wr = 0;
    run(4);
    check("t4_resp_count", 64'(dut_resp_q.size()), 64'(1));
    if (dut_resp_q.size() >= 1) check("t4_lsu_resp", 64'(dut_resp_q[0]), 64'(1));

    // Flush coincident with mem_ack on a fetch: no ack, response drained.
    dut_grant_q.delete(); dut_resp_q.delete();
    ifu_pend = 1; f_addr = 32'h1C00_0080;
    run(1);
    cancel_now = 1;
    run(1);
    cancel_now = 0;
    run(3);
    check("t5_ack_count", 64'(dut_grant_q.size()), 64'(1));
    if (dut_grant_q.size() >= 1) check("t5_no_ack", 64'(dut_grant_q[0]), 64'(2));
    check("t5_no_resp", 64'(dut_resp_q.size()), 64'(0));

    // LSU write, then reset asserted in the middle of WAIT.
    lsu_pend = 1; l_addr = 32'h0000_2000; l_wr = 1;
    l_wdata = 64'hDEAD_BEEF_CAFE_F00D; l_wstrb = 8'h0F;
    ack_sel = 0; rvld_sel = 3;
    run(2);
    check("t6_wstrb", 64'(mem_bus.mem_wstrb), 64'(8'h0F));
    run(1);
    #2;
    reset = 1'b1;
    #1;
    check_zero("t6_async");
    do_reset();
    rvld_sel = 0;
    ifu_pend = 1; f_addr = 32'h1C00_0100;
    run(5);

    // Randomized traffic with occasional flushes and variable bus latency.
    do_reset();
    lsu_pct = 30; ifu_pct = 30; cancel_pct = 5;
    ack_sel = -1; rvld_sel = -1;
    run(1500);
    lsu_pct = 0; ifu_pct = 0; cancel_pct = 0;
    run(30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
